// File: rtl/uart_seq_pkg.sv
// Shared constants and state encoding for the UART transmit sequencer.
package uart_seq_pkg;

  localparam int DEFAULT_ADDR_WIDTH   = 16;
  localparam int DEFAULT_GUARD_CYCLES = 607;
  localparam int CLOCKS_PER_BIT       = 55;

  typedef logic [3:0] state_t;

  localparam state_t S_GUARD     = 4'd0;
  localparam state_t S_IDLE      = 4'd1;
  localparam state_t S_FETCH     = 4'd2;
  localparam state_t S_LATCH     = 4'd3;
  localparam state_t S_PULSE     = 4'd4;
  localparam state_t S_WAIT_CLR  = 4'd5;
  localparam state_t S_WAIT_DONE = 4'd6;
  localparam state_t S_GAP       = 4'd7;
  localparam state_t S_CSUM      = 4'd8;
  localparam state_t S_FINISH    = 4'd9;

endpackage

// File: rtl/uart_tx_sequencer.sv
// Streams a block of bytes from byte memory through a start/done UART transmitter.
// Optional trailing checksum byte when UART_SEQ_CHECKSUM_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// GUARD     | post-reset lockout so an in-flight frame can finish
// IDLE      | waiting for start
// FETCH     | memory read strobe at addr_q
// LATCH     | capture read data into tx_byte
// PULSE     | one-cycle tx_start
// WAIT_CLR  | wait for tx_done to drop (ignore stale done of last frame)
// WAIT_DONE | wait for tx_done to rise, advance counters
// GAP       | inter-frame idle time
// CSUM      | load accumulated checksum into tx_byte (checksum build only)
// FINISH    | one-cycle done pulse
module uart_tx_sequencer
  import uart_seq_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int GAP_CYCLES   = 0,
  parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] byte_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [7:0]            mem_rd_data,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  input  logic                  tx_done,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bytes_sent
);

  // One down-counter serves both the guard lockout and the inter-frame gap.
  localparam int CNT_MAX = (GUARD_CYCLES > GAP_CYCLES) ? GUARD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE      = ADDR_WIDTH'(1);

`ifdef UART_SEQ_CHECKSUM_EN
  localparam state_t LAST_NEXT = S_CSUM;
`else
  localparam state_t LAST_NEXT = S_FINISH;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   remaining;
`ifdef UART_SEQ_CHECKSUM_EN
  logic [7:0]              sum_q;
  logic                    csum_phase;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_GUARD;
      cnt        <= GUARD_LOAD;
      addr_q     <= '0;
      remaining  <= '0;
      tx_byte    <= '0;
      bytes_sent <= '0;
`ifdef UART_SEQ_CHECKSUM_EN
      sum_q      <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      case (state)
        S_GUARD: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CNT_ONE;
        end
        S_IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            remaining  <= byte_count;
            bytes_sent <= '0;
`ifdef UART_SEQ_CHECKSUM_EN
            sum_q      <= '0;
            csum_phase <= 1'b0;
`endif
            state <= (byte_count == '0) ? LAST_NEXT : S_FETCH;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          tx_byte <= mem_rd_data;
`ifdef UART_SEQ_CHECKSUM_EN
          sum_q   <= sum_q + mem_rd_data;
`endif
          state   <= S_PULSE;
        end
        S_PULSE: state <= S_WAIT_CLR;
        S_WAIT_CLR: begin
          if (!tx_done) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
`ifdef UART_SEQ_CHECKSUM_EN
            if (csum_phase) state <= S_FINISH;
            else
`endif
            begin
              bytes_sent <= bytes_sent + A_ONE;
              remaining  <= remaining - A_ONE;
              addr_q     <= addr_q + A_ONE;
              if (remaining == A_ONE) begin
                state <= LAST_NEXT;
              end else if (GAP_CYCLES > 0) begin
                cnt   <= GAP_LOAD;
                state <= S_GAP;
              end else begin
                state <= S_FETCH;
              end
            end
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_FETCH;
          else           cnt   <= cnt - CNT_ONE;
        end
`ifdef UART_SEQ_CHECKSUM_EN
        S_CSUM: begin
          tx_byte    <= sum_q;
          csum_phase <= 1'b1;
          state      <= S_PULSE;
        end
`endif
        S_FINISH: state <= S_IDLE;
        default:  state <= S_GUARD;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_rd_en = (state == S_FETCH);
  assign tx_start  = (state == S_PULSE);
  assign done      = (state == S_FINISH);
  assign busy      = (state != S_IDLE);

endmodule
